// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial sequence detector.
package seq_det_pkg;

  localparam int         PATTERN_W_MAX   = 16;
  localparam int         COUNT_W         = 8;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

  // Width of a counter that must reach w-1; never narrower than one bit.
  function automatic int fill_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// COUNT_W-bit up counter that sticks at its maximum value.
module seq_det_sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = COUNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial pattern detector with overlapping or non-overlapping matching.
// Defining SEQ_DET_COUNT_EN adds the saturating match_count output.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEFAULT_PATTERN),
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               input_bit,
  input  logic               in_valid,
`ifdef SEQ_DET_COUNT_EN
  output logic [COUNT_W-1:0] match_count,
`endif
  output logic               output_bit
);

  localparam int                FILL_W    = fill_width(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W - 1);

  logic [PATTERN_W-2:0] hist, hist_nxt;
  logic [FILL_W-1:0]    fill, fill_nxt;
  logic [PATTERN_W-1:0] window;
  logic                 match;

  // Oldest history bit sits at the MSB so the window lines up with PATTERN.
  assign window = {hist, input_bit};

  // fill guards against a zero-filled history aliasing a pattern with leading zeros.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    match    = rst && in_valid && (fill == FILL_FULL) && (window == PATTERN);
    hist_nxt = hist;
    fill_nxt = fill;
    if (in_valid) begin
      if (match && !OVERLAP) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end else begin
        hist_nxt = window[PATTERN_W-2:0];
        if (fill != FILL_FULL) begin
          fill_nxt = fill + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_nxt;
      fill <= fill_nxt;
    end
  end

  assign output_bit = match;

`ifdef SEQ_DET_COUNT_EN
  seq_det_sat_counter #(
    .W(COUNT_W)
  ) u_match_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (match),
    .count(match_count)
  );
`endif

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PATTERN_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1101: target sequence, MSB received first, PATTERN_W bits wide.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 input_bit  input  1  serial data bit, sampled on the rising clk edge.
REQ-007 in_valid  input  1  qualifies input_bit; when low, input_bit is ignored.
REQ-008 output_bit  output  1  Mealy match flag, combinational from current state, input_bit and in_valid.
REQ-009 match_count  output  8  count of detected matches; present only with SEQ_DET_COUNT_EN.

Function
REQ-010 Internal state: history register hist of PATTERN_W-1 bits and fill counter fill, range 0..PATTERN_W-1.
REQ-011 output_bit = in_valid AND (fill == PATTERN_W-1) AND ({hist, input_bit} == PATTERN), same cycle, zero-cycle latency.
REQ-012 On an edge with in_valid=1 and no match: hist shifts left taking input_bit into the LSB; fill increments, saturating at PATTERN_W-1.
REQ-013 On an edge with in_valid=1, a match and OVERLAP=1: hist shifts as in REQ-012; fill stays at PATTERN_W-1, so suffix bits count towards the next match.
REQ-014 On an edge with in_valid=1, a match and OVERLAP=0: hist is cleared to 0 and fill to 0; no bit of the matched sequence is reused.
REQ-015 On an edge with in_valid=0: hist and fill hold; output_bit = 0.
REQ-016 No match is flagged until PATTERN_W valid bits have been received since reset or since the last non-overlap match; zero-filled history never produces a match.
REQ-017 Matches are flagged back-to-back on consecutive valid cycles when the pattern permits (e.g. PATTERN all ones, OVERLAP=1).

Reset
REQ-018 rst low at a rising edge: hist = 0, fill = 0, match_count = 0; this overrides in_valid and input_bit.
REQ-019 While rst is low, output_bit = 0 regardless of input_bit.
REQ-020 Reset asserted mid-sequence discards the partial match; detection restarts with the first valid bit after reset deasserts.

Configuration
REQ-021 Macro SEQ_DET_COUNT_EN defined: the match_count port exists and increments by 1 on each edge where output_bit = 1, saturating at 255.
REQ-022 Macro SEQ_DET_COUNT_EN undefined: no match_count port and no counter logic; all other behaviour is identical.

Structure
REQ-023 Package seq_det_pkg holds PATTERN_W_MAX = 16, COUNT_W = 8 and the default pattern constant DEFAULT_PATTERN = 4'b1101.
REQ-024 Optional sub-module seq_det_sat_counter: the COUNT_W-bit saturating counter, instantiated only under SEQ_DET_COUNT_EN.
REQ-025 Matching logic stays in seq_detector_param; no further hierarchy.

Verification (PATTERN_W=4, PATTERN=1101, in_valid=1 unless stated)
REQ-026 Hold rst low for 2 cycles, then input 1,1,0,1,1,1,0,1 -> output_bit high on bits 4 and 8 only; match_count = 2.
REQ-027 OVERLAP=1, input 1,1,0,1,1,0,1 -> matches on bits 4 and 7; OVERLAP=0, same input -> match on bit 4 only.
REQ-028 Input 1,1,0 with in_valid=1, then in_valid=0 for 3 cycles driving input_bit=1, then 1 with in_valid=1 -> output_bit low during the stall; single match on the final bit.
REQ-029 Input 1,1,0, assert rst for 1 cycle, then input 1 -> no match; then 1,0,1 -> match on the last bit.
REQ-030 First 3 valid bits after reset equal to 1,0,1 -> no match; this checks REQ-016.
REQ-031 Under SEQ_DET_COUNT_EN, PATTERN=4'b1111 with OVERLAP=1 and 300 consecutive ones -> match_count saturates at 255 and holds.
